// File: rtl/counter_monitor_pkg.sv
// rtl/counter_monitor_pkg.sv - shared types and constants for the counter monitor
// Holds the FSM state enum, the LFSR tap mask, the default seed and the LFSR step helper.
package counter_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUN,
    ST_DONE
  } state_t;

  // x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register taps bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [7:0] legal_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/counter_monitor_lfsr8.sv
// rtl/counter_monitor_lfsr8.sv - 8-bit Fibonacci LFSR used to randomise the counter enable
// Ports: clk, rst (sync, active high, loads seed), load (load seed),
//        advance (step once), seed[7:0], state[7:0] (current register value).
module lfsr8
  import counter_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      state <= seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// rtl/counter_monitor.sv - drives an 8-bit counter under test and checks its count sequence
// Ports: clk, rst (sync, active high), start (one-cycle run request),
//        rand_mode (sampled at start: 1 = LFSR enable pattern, 0 = enable held high),
//        cnt_in[7:0] (counter value), cnt_en (counter enable), busy, done (one-cycle pulse),
//        pass (last run had no errors), err_cnt[7:0] (saturating), first_bad[7:0].
module counter_monitor
  import counter_monitor_pkg::*;
#(
  parameter int         RUN_LEN = 16,
  parameter logic [7:0] SEED    = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rand_mode,
  input  logic [7:0] cnt_in,
  output logic       cnt_en,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [7:0] first_bad
);

  localparam logic [7:0] SEED_EFF    = legal_seed(SEED);
  localparam logic [7:0] LAST_SAMPLE = 8'(RUN_LEN - 1);

  state_t     state;
  logic       rand_mode_q;
  logic [7:0] exp_q;
  logic [7:0] sample_cnt;
  logic [7:0] lfsr;
  logic       mismatch;
  logic [7:0] err_next;
  logic       unused_lfsr_hi;

  lfsr8 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    ((state == ST_IDLE) && start),
    .advance (state == ST_RUN),
    .seed    (SEED_EFF),
    .state   (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[7:1];

  // Outputs decode only registered state, so they change only on clock edges
  assign cnt_en = (state == ST_RUN) && (rand_mode_q ? lfsr[0] : 1'b1);
  assign busy   = (state == ST_SYNC) || (state == ST_RUN);
  assign done   = (state == ST_DONE);

  assign mismatch = (cnt_in != exp_q);

  always_comb begin
    err_next = err_cnt;
    if (mismatch && (err_cnt != 8'hFF)) begin
      err_next = err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rand_mode_q <= 1'b0;
      exp_q       <= 8'h00;
      sample_cnt  <= 8'h00;
      err_cnt     <= 8'h00;
      first_bad   <= 8'h00;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_SYNC;
            err_cnt     <= 8'h00;
            first_bad   <= 8'h00;
            pass        <= 1'b0;
            rand_mode_q <= rand_mode;
          end
        end
        ST_SYNC: begin
          // The counter is held this cycle, so its current value is the first expectation
          exp_q      <= cnt_in;
          sample_cnt <= 8'h00;
          state      <= ST_RUN;
        end
        ST_RUN: begin
          err_cnt <= err_next;
          // err_cnt is cleared at start, so zero here means no earlier mismatch in this run
          if (mismatch && (err_cnt == 8'h00)) begin
            first_bad <= cnt_in;
          end
          // Predict from the observed value so one bad sample does not cascade
          exp_q      <= cnt_in + {7'd0, cnt_en};
          sample_cnt <= sample_cnt + 8'd1;
          if (sample_cnt == LAST_SAMPLE) begin
            state <= ST_DONE;
            // Uses the updated count so pass is valid alongside done
            pass  <= (err_next == 8'h00);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_monitor.sv
// tb/tb_counter_monitor.sv - directed self-checking bench for counter_monitor
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b, rand_mode_a;
  logic [7:0] cnt_a, cnt_b;
  logic       en_a, busy_a, done_a, pass_a;
  logic [7:0] err_a, fb_a;
  logic       en_b, busy_b, done_b, pass_b;
  logic [7:0] err_b, fb_b;

  logic       ctr_load;
  logic [7:0] ctr_load_val;
  logic       stuck;

  int n_checks = 0;
  int n_fail   = 0;

  int          dc;
  logic [15:0] ew;
  logic [15:0] exp_word;
  logic [7:0]  l;
  int          dcb;

  always #5 clk = ~clk;

  // Counter under test for dut_a: good (increments on enable) or stuck
  always @(posedge clk) begin
    if (ctr_load) cnt_a <= ctr_load_val;
    else if (!stuck && en_a) cnt_a <= cnt_a + 8'd1;
  end

  // Faulty counter for dut_b: steps by 2 every cycle, so every sample mismatches
  always @(posedge clk) begin
    if (rst) cnt_b <= 8'd0;
    else cnt_b <= cnt_b + 8'd2;
  end

  counter_monitor #(.RUN_LEN(16), .SEED(8'hA5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rand_mode(rand_mode_a), .cnt_in(cnt_a),
    .cnt_en(en_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_bad(fb_a)
  );

  counter_monitor #(.RUN_LEN(255), .SEED(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rand_mode(1'b0), .cnt_in(cnt_b),
    .cnt_en(en_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_bad(fb_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pulses start, records cnt_en over the 16 RUN cycles, returns the cycle done was seen
  task automatic run_a(input logic rm, output int done_cyc, output logic [15:0] en_word);
    en_word  = 16'h0;
    done_cyc = -1;
    @(negedge clk);
    start_a     = 1'b1;
    rand_mode_a = rm;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      if (cyc >= 2 && cyc <= 17) en_word[cyc-2] = en_a;
      if (done_a) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic load_ctr(input logic [7:0] v);
    @(negedge clk);
    ctr_load     = 1'b1;
    ctr_load_val = v;
    @(posedge clk);
    @(negedge clk);
    ctr_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; rand_mode_a = 1'b0;
    ctr_load = 1'b1; ctr_load_val = 8'd0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_done",  32'(done_a), 32'd0);
    check("rst_pass",  32'(pass_a), 32'd0);
    check("rst_err",   32'(err_a),  32'd0);
    check("rst_fb",    32'(fb_a),   32'd0);
    check("rst_en",    32'(en_a),   32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0; ctr_load = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_busy", 32'(busy_a), 32'd0);
    check("post_rst_en",   32'(en_a),   32'd0);
    check("post_rst_done", 32'(done_a), 32'd0);

    // Good counter from 0, enable held high
    load_ctr(8'd0);
    run_a(1'b0, dc, ew);
    check("t1_done_cyc", 32'(dc),     32'd18);
    check("t1_en_word",  32'(ew),     32'h0000FFFF);
    check("t1_pass",     32'(pass_a), 32'd1);
    check("t1_err",      32'(err_a),  32'd0);
    check("t1_fb",       32'(fb_a),   32'd0);
    check("t1_en_done",  32'(en_a),   32'd0);
    // start during DONE is ignored
    start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
    check("t1_start_in_done_busy", 32'(busy_a), 32'd0);
    check("t1_pass_held",          32'(pass_a), 32'd1);
    check("t1_done_pulse",         32'(done_a), 32'd0);

    // Good counter crossing 255 -> 0
    load_ctr(8'd250);
    run_a(1'b0, dc, ew);
    check("t2_done_cyc", 32'(dc),     32'd18);
    check("t2_pass",     32'(pass_a), 32'd1);
    check("t2_err",      32'(err_a),  32'd0);

    // LFSR enable pattern against reference sequence from seed A5
    l = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      exp_word[k] = l[0];
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    load_ctr(8'd0);
    run_a(1'b1, dc, ew);
    check("t3_done_cyc", 32'(dc),     32'd18);
    check("t3_en_word",  32'(ew),     32'(exp_word));
    check("t3_pass",     32'(pass_a), 32'd1);
    check("t3_err",      32'(err_a),  32'd0);

    // Counter stuck at 7
    load_ctr(8'h07);
    stuck = 1'b1;
    run_a(1'b0, dc, ew);
    check("t4_done_cyc", 32'(dc),     32'd18);
    check("t4_err",      32'(err_a),  32'd15);
    check("t4_fb",       32'(fb_a),   32'h07);
    check("t4_pass",     32'(pass_a), 32'd0);

    // Reset in the 5th RUN cycle; start during RUN ignored (counter still stuck at 7)
    @(negedge clk);
    start_a = 1'b1; rand_mode_a = 1'b0;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
    check("t5_sync_en",   32'(en_a),   32'd0);
    check("t5_sync_busy", 32'(busy_a), 32'd1);
    @(posedge clk); @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); @(negedge clk);
    start_a = 1'b0;
    check("t5_run_start_ign_en", 32'(en_a),   32'd1);
    check("t5_run_busy",         32'(busy_a), 32'd1);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("t5_err_before_rst", 32'(err_a), 32'd3);
    check("t5_fb_before_rst",  32'(fb_a),  32'h07);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("t5_rst_busy", 32'(busy_a), 32'd0);
    check("t5_rst_en",   32'(en_a),   32'd0);
    check("t5_rst_err",  32'(err_a),  32'd0);
    check("t5_rst_fb",   32'(fb_a),   32'd0);
    @(posedge clk); @(negedge clk);
    check("t5_idle_busy", 32'(busy_a), 32'd0);
    check("t5_idle_done", 32'(done_a), 32'd0);

    // Error on every sample, RUN_LEN=255: err_cnt saturates at 255
    dcb = -1;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); @(negedge clk);
      start_b = 1'b0;
      if (done_b) begin
        dcb = cyc;
        break;
      end
    end
    check("t6_done_cyc", 32'(dcb),    32'd257);
    check("t6_err_sat",  32'(err_b),  32'd255);
    check("t6_pass",     32'(pass_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter RUN_LEN, default 16: number of compared samples per run (1..255).
REQ-002 Parameter SEED, default 8'hA5: LFSR seed; value 0 is illegal and is replaced by 8'h01.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  single-cycle request to begin a run.
REQ-006 rand_mode  in  1  sampled at start; 1 = LFSR enable pattern, 0 = enable held high.
REQ-007 cnt_in  in  8  count value returned by the 8-bit counter under test.
REQ-008 cnt_en  out  1  enable to the counter under test (drives its ui_in[0]).
REQ-009 busy  out  1  high from the SYNC state through the RUN state.
REQ-010 done  out  1  one-cycle pulse when a run ends.
REQ-011 pass  out  1  high when the last run completed with zero errors; held until the next start.
REQ-012 err_cnt  out  8  mismatches in the last/current run; saturates at 255.
REQ-013 first_bad  out  8  cnt_in value at the first mismatch of the run; 0 if there is none.

Function
REQ-014 Counter contract: if cnt_en=1 in cycle t, then cnt_in(t+1) = cnt_in(t)+1 mod 256; otherwise cnt_in(t+1) = cnt_in(t).
REQ-015 FSM states: IDLE, SYNC, RUN, DONE.
REQ-016 IDLE: cnt_en=0; start=1 -> SYNC, clear err_cnt/first_bad/pass, latch rand_mode, load the LFSR with SEED.
REQ-017 SYNC (exactly 1 cycle): cnt_en=0; exp <= cnt_in; sample counter <= 0; go to RUN.
REQ-018 RUN: cnt_en = rand_mode_q ? lfsr[0] : 1; the LFSR advances every RUN cycle.
REQ-019 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts left, feedback enters bit 0.
REQ-020 RUN compare: each cycle compare cnt_in to exp. A mismatch increments err_cnt (saturating) and captures first_bad if it is the first mismatch.
REQ-021 Next expected value: exp <= cnt_in + cnt_en (mod 256), so the checker resynchronises after an error.
REQ-022 Wrap-around: exp=255 with cnt_en=1 expects 0; this is not an error.
REQ-023 After RUN_LEN compares -> DONE. DONE (1 cycle): done=1, cnt_en=0, pass=(err_cnt==0), go to IDLE.
REQ-024 start while busy, or during DONE, is ignored.
REQ-025 Latency: start at cycle 0 gives the first compare at cycle 2 and done at cycle RUN_LEN+2.

Reset
REQ-026 rst has priority over start and acts in any state, including mid-run: state=IDLE, cnt_en=0, busy=0, done=0, pass=0, err_cnt=0, first_bad=0, exp=0, LFSR=SEED.
REQ-027 No output toggles in the cycle that follows reset unless start is asserted.

Structure
REQ-028 A shared package holds the FSM state enum, the LFSR tap constant 8'hB8 and the default SEED.
REQ-029 A single sub-module, lfsr8 (load, advance, seed; 8-bit state output), implements the LFSR; all other logic lives in counter_monitor.

Verification
REQ-030 Good counter, rand_mode=0, RUN_LEN=16, counter starting at 0 -> cnt_en high for 16 cycles, done at cycle 18, pass=1, err_cnt=0.
REQ-031 Good counter starting at 250, rand_mode=0 -> the wrap 255->0 is accepted, pass=1.
REQ-032 Counter stuck at 8'h07, rand_mode=0 -> first_bad=8'h07, err_cnt=15 (the first compare matches), pass=0.
REQ-033 Good counter, rand_mode=1, SEED=8'hA5 -> the cnt_en sequence equals the reference-model LFSR bits, pass=1.
REQ-034 Assert rst in the 5th RUN cycle -> the next cycle shows IDLE, cnt_en=0, err_cnt=0; a start pulse during RUN has no effect.
REQ-035 Counter forced to an error on every sample with RUN_LEN=255 -> err_cnt saturates at 255 and does not wrap.
